// File: rtl/pwm_softstep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_softstep_ctrl_if
// Description : Front-panel / PWM-datapath bundle for the soft-step sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_softstep_ctrl_if #(
    parameter int FREQ_W = 3,
    parameter int DUTY_W = 5
);
    logic              enable;
    logic              sel_f_i;
    logic              btn_up;
    logic              btn_down;
    logic              period_wrap;
    logic [FREQ_W-1:0] freq_sel;
    logic [DUTY_W-1:0] duty_code;
    logic [FREQ_W-1:0] tgt_freq;
    logic [DUTY_W-1:0] tgt_duty;
    logic              busy;
    logic [2:0]        state;

    modport master (
        output enable, sel_f_i, btn_up, btn_down, period_wrap,
        input  freq_sel, duty_code, tgt_freq, tgt_duty, busy, state
    );

    modport slave (
        input  enable, sel_f_i, btn_up, btn_down, period_wrap,
        output freq_sel, duty_code, tgt_freq, tgt_duty, busy, state
    );
endinterface
`default_nettype wire

// File: rtl/pwm_softstep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_softstep_ctrl
// Description : Holds user freq/duty targets and applies them glitch-free:
//               duty ramps one code per STEP_PERIODS PWM periods, a frequency
//               change drains duty to 0 and swaps freq_sel on a period wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_softstep_ctrl #(
    parameter int FREQ_W       = 3,
    parameter int DUTY_W       = 5,
    parameter int DUTY_MAX     = 20,
    parameter int STEP_PERIODS = 4
) (
    input  logic                clk,
    input  logic                rst,
    pwm_softstep_ctrl_if.slave  bus
);

    localparam int CNT_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [FREQ_W-1:0] C_FREQ_MAX  = '1;
    localparam logic [DUTY_W-1:0] C_DUTY_MAX  = DUTY_W'(DUTY_MAX);
    localparam logic [CNT_W-1:0]  C_STEP_LAST = CNT_W'(STEP_PERIODS - 1);

    typedef enum logic [2:0] {
        ST_OFF    = 3'd0,
        ST_RUN    = 3'd1,
        ST_RAMP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_SWITCH = 3'd4
    } state_t;

    state_t              state_q,     state_d;
    logic [FREQ_W-1:0]   freq_sel_q,  freq_sel_d;
    logic [DUTY_W-1:0]   duty_code_q, duty_code_d;
    logic [FREQ_W-1:0]   tgt_freq_q,  tgt_freq_d;
    logic [DUTY_W-1:0]   tgt_duty_q,  tgt_duty_d;
    logic [CNT_W-1:0]    step_cnt_q,  step_cnt_d;
    logic                btn_up_q,    btn_down_q;
    logic                busy_q,      busy_d;

    logic w_up_e;
    logic w_down_e;
    logic w_step_tick;
    logic w_freq_mis;
    logic w_duty_eq;
    logic w_leave;

    assign w_up_e      = bus.btn_up   & ~btn_up_q;
    assign w_down_e    = bus.btn_down & ~btn_down_q;
    assign w_step_tick = bus.period_wrap & (step_cnt_q == C_STEP_LAST);
    assign w_freq_mis  = (freq_sel_q != tgt_freq_q);
    assign w_duty_eq   = (duty_code_q == tgt_duty_q);
    assign w_leave     = ~bus.enable | w_freq_mis;

    // Target editing: exactly one fresh edge edits, both edges together cancel.
    always_comb begin
        tgt_freq_d = tgt_freq_q;
        tgt_duty_d = tgt_duty_q;
        if (w_up_e && !w_down_e) begin
            if (bus.sel_f_i) begin
                if (tgt_freq_q != C_FREQ_MAX) tgt_freq_d = tgt_freq_q + 1'b1;
            end else begin
                if (tgt_duty_q < C_DUTY_MAX)  tgt_duty_d = tgt_duty_q + 1'b1;
            end
        end else if (w_down_e && !w_up_e) begin
            if (bus.sel_f_i) begin
                if (tgt_freq_q != '0) tgt_freq_d = tgt_freq_q - 1'b1;
            end else begin
                if (tgt_duty_q != '0) tgt_duty_d = tgt_duty_q - 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        freq_sel_d  = freq_sel_q;
        duty_code_d = duty_code_q;
        step_cnt_d  = step_cnt_q;

        unique case (state_q)
            ST_OFF: begin
                duty_code_d = '0;
                freq_sel_d  = tgt_freq_q;
                step_cnt_d  = '0;
                if (bus.enable) state_d = ST_RUN;
            end

            ST_RUN: begin
                step_cnt_d = '0;
                if (w_leave)         state_d = ST_DRAIN;
                else if (!w_duty_eq) state_d = ST_RAMP;
            end

            ST_RAMP: begin
                if (w_leave) begin
                    state_d    = ST_DRAIN;
                    step_cnt_d = '0;
                end else begin
                    if (bus.period_wrap)
                        step_cnt_d = w_step_tick ? '0 : step_cnt_q + 1'b1;
                    // Direction is re-derived at every step so target edits mid-ramp are tracked.
                    if (w_step_tick && !w_duty_eq) begin
                        if (duty_code_q < tgt_duty_q) duty_code_d = duty_code_q + 1'b1;
                        else                          duty_code_d = duty_code_q - 1'b1;
                    end
                    if (w_duty_eq) begin
                        state_d    = ST_RUN;
                        step_cnt_d = '0;
                    end
                end
            end

            ST_DRAIN: begin
                if (duty_code_q == '0) begin
                    step_cnt_d = '0;
                    if (!bus.enable)     state_d = ST_OFF;
                    else if (w_freq_mis) state_d = ST_SWITCH;
                    else                 state_d = ST_RAMP;
                end else begin
                    if (bus.period_wrap)
                        step_cnt_d = w_step_tick ? '0 : step_cnt_q + 1'b1;
                    if (w_step_tick) duty_code_d = duty_code_q - 1'b1;
                end
            end

            ST_SWITCH: begin
                step_cnt_d = '0;
                if (!bus.enable) begin
                    state_d = ST_OFF;
                end else if (bus.period_wrap) begin
                    // Swap only on a wrap so the mux never changes mid-period.
                    freq_sel_d = tgt_freq_q;
                    state_d    = (tgt_duty_q != '0) ? ST_RAMP : ST_RUN;
                end
            end

            default: begin
                state_d     = ST_OFF;
                duty_code_d = '0;
                step_cnt_d  = '0;
            end
        endcase
    end

    assign busy_d = (state_d == ST_RAMP) || (state_d == ST_DRAIN) || (state_d == ST_SWITCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_OFF;
            freq_sel_q  <= '0;
            duty_code_q <= '0;
            tgt_freq_q  <= '0;
            tgt_duty_q  <= '0;
            step_cnt_q  <= '0;
            btn_up_q    <= 1'b0;
            btn_down_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            freq_sel_q  <= freq_sel_d;
            duty_code_q <= duty_code_d;
            tgt_freq_q  <= tgt_freq_d;
            tgt_duty_q  <= tgt_duty_d;
            step_cnt_q  <= step_cnt_d;
            btn_up_q    <= bus.btn_up;
            btn_down_q  <= bus.btn_down;
            busy_q      <= busy_d;
        end
    end

    assign bus.freq_sel  = freq_sel_q;
    assign bus.duty_code = duty_code_q;
    assign bus.tgt_freq  = tgt_freq_q;
    assign bus.tgt_duty  = tgt_duty_q;
    assign bus.busy      = busy_q;
    assign bus.state     = state_q;

endmodule
`default_nettype wire
